seg_scan_decoder: RTL

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_pkg.sv | 59 +++++
 rtl/seg_scan_decoder_if.sv | 24 ++
 rtl/seg_pattern_decode.sv | 22 ++
 rtl/seg_scan_decoder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan decoder:
// segment codes, FSM states, parameter defaults and anode helpers.
package seg_pkg;

    localparam int unsigned SETTLE_DEFAULT  = 4;
    localparam int unsigned TIMEOUT_DEFAULT = 1_000_000;

    // Codes are light[7:1], i.e. {a,b,c,d,e,f,g}, active-low.
    localparam logic [6:0] SEG_CODE_0 = 7'h01;
    localparam logic [6:0] SEG_CODE_1 = 7'h4F;
    localparam logic [6:0] SEG_CODE_2 = 7'h12;
    localparam logic [6:0] SEG_CODE_3 = 7'h06;
    localparam logic [6:0] SEG_CODE_4 = 7'h4C;
    localparam logic [6:0] SEG_CODE_5 = 7'h24;
    localparam logic [6:0] SEG_CODE_6 = 7'h20;
    localparam logic [6:0] SEG_CODE_7 = 7'h0F;
    localparam logic [6:0] SEG_CODE_8 = 7'h00;
    localparam logic [6:0] SEG_CODE_9 = 7'h04;
    localparam logic [6:0] SEG_CODE_A = 7'h08;
    localparam logic [6:0] SEG_CODE_B = 7'h60;
    localparam logic [6:0] SEG_CODE_C = 7'h31;
    localparam logic [6:0] SEG_CODE_D = 7'h42;
    localparam logic [6:0] SEG_CODE_E = 7'h30;
    localparam logic [6:0] SEG_CODE_F = 7'h38;

    localparam logic [6:0] SEG_CODES [16] = '{
        SEG_CODE_0, SEG_CODE_1, SEG_CODE_2, SEG_CODE_3,
        SEG_CODE_4, SEG_CODE_5, SEG_CODE_6, SEG_CODE_7,
        SEG_CODE_8, SEG_CODE_9, SEG_CODE_A, SEG_CODE_B,
        SEG_CODE_C, SEG_CODE_D, SEG_CODE_E, SEG_CODE_F
    };

    typedef enum logic [1:0] {
        BLANK    = 2'd0,
        SETTLING = 2'd1,
        HELD     = 2'd2
    } scan_state_e;

    function automatic logic isOneHotLow(input logic [3:0] an);
        logic result;
        case (an)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: result = 1'b1;
            default:                             result = 1'b0;
        endcase
        return result;
    endfunction

    function automatic logic [1:0] digitIndex(input logic [3:0] an);
        logic [1:0] result;
        case (an)
            4'b1101: result = 2'd1;
            4'b1011: result = 2'd2;
            4'b0111: result = 2'd3;
            default: result = 2'd0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Bundle between a multiplexed seven-segment driver (master) and the
// scan decoder (slave) that recovers the displayed hex word.
interface seg_scan_decoder_if;

    logic [3:0]  an;
    logic [7:0]  light;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  digit_err;
    logic        valid;
    logic        err;
    logic        frame_done;

    modport master (
        output an, light,
        input  value, dp, digit_err, valid, err, frame_done
    );

    modport slave (
        input  an, light,
        output value, dp, digit_err, valid, err, frame_done
    );

endinterface

// File: rtl/seg_pattern_decode.sv
// Combinational lookup from an active-low 7-segment pattern to a hex
// nibble; unknown patterns give nibble 0 with invalid set.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] nibble_o,
    output logic       invalid_o
);

    always_comb begin
        nibble_o  = 4'h0;
        invalid_o = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (pattern_i == SEG_CODES[i]) begin
                nibble_o  = 4'(i);
                invalid_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Sniffs a multiplexed 4-digit seven-segment bus, captures each digit once
// it has been stable for SETTLE cycles, and publishes whole frames.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int unsigned SETTLE  = SETTLE_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input logic               clk,
    input logic               rst,
    seg_scan_decoder_if.slave bus
);

    localparam logic [7:0]  SETTLE_CNT  = 8'(SETTLE);
    localparam logic [23:0] TIMEOUT_CNT = 24'(TIMEOUT);

    logic [3:0]  anIn_q, anPrev_q;
    logic [7:0]  lightIn_q, lightPrev_q;
    scan_state_e state_q, state_d;
    logic [7:0]  stableCnt_q, stableCnt_d;
    logic [3:0]  capturedMask_q, capturedMask_d;
    logic [15:0] shadowValue_q;
    logic [3:0]  shadowDp_q, shadowErr_q;
    logic [15:0] value_q;
    logic [3:0]  dp_q, digitErr_q;
    logic        err_q, valid_q, frameDone_q;
    logic [23:0] timeoutCnt_q;

    logic        inputChanged, anOneHot, capture, frameComplete;
    logic [1:0]  digitSel;
    logic [3:0]  decNibble;
    logic        decInvalid;

    assign inputChanged  = (anIn_q != anPrev_q) || (lightIn_q != lightPrev_q);
    assign anOneHot      = isOneHotLow(anIn_q);
    assign digitSel      = digitIndex(anIn_q);
    assign frameComplete = (capturedMask_q == 4'hF);

    seg_pattern_decode u_decode (
        .pattern_i (lightIn_q[7:1]),
        .nibble_o  (decNibble),
        .invalid_o (decInvalid)
    );

    // The previous-cycle copies let the FSM see any change on the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anIn_q      <= 4'hF;
            lightIn_q   <= 8'hFF;
            anPrev_q    <= 4'hF;
            lightPrev_q <= 8'hFF;
        end else begin
            anIn_q      <= bus.an;
            lightIn_q   <= bus.light;
            anPrev_q    <= anIn_q;
            lightPrev_q <= lightIn_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        stableCnt_d = stableCnt_q;
        capture     = 1'b0;
        unique case (state_q)
            BLANK: begin
                if (anOneHot) begin
                    state_d     = SETTLING;
                    stableCnt_d = 8'd1;
                end else begin
                    stableCnt_d = 8'd0;
                end
            end
            SETTLING: begin
                if (inputChanged) begin
                    if (anOneHot) begin
                        stableCnt_d = 8'd1;
                    end else begin
                        state_d     = BLANK;
                        stableCnt_d = 8'd0;
                    end
                end else if (stableCnt_q + 8'd1 == SETTLE_CNT) begin
                    state_d     = HELD;
                    stableCnt_d = SETTLE_CNT;
                    capture     = 1'b1;
                end else begin
                    stableCnt_d = stableCnt_q + 8'd1;
                end
            end
            HELD: begin
                if (inputChanged) begin
                    if (anOneHot) begin
                        state_d     = SETTLING;
                        stableCnt_d = 8'd1;
                    end else begin
                        state_d     = BLANK;
                        stableCnt_d = 8'd0;
                    end
                end
            end
            default: begin
                state_d     = BLANK;
                stableCnt_d = 8'd0;
            end
        endcase
    end

    // A capture landing in the publish cycle still counts toward the next frame.
    always_comb begin
        capturedMask_d = frameComplete ? 4'h0 : capturedMask_q;
        if (capture) begin
            capturedMask_d[digitSel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= BLANK;
            stableCnt_q    <= 8'd0;
            capturedMask_q <= 4'h0;
            shadowValue_q  <= 16'h0000;
            shadowDp_q     <= 4'h0;
            shadowErr_q    <= 4'h0;
        end else begin
            state_q        <= state_d;
            stableCnt_q    <= stableCnt_d;
            capturedMask_q <= capturedMask_d;
            if (capture) begin
                shadowValue_q[{digitSel, 2'b00} +: 4] <= decNibble;
                shadowDp_q[digitSel]                  <= ~lightIn_q[0];
                shadowErr_q[digitSel]                 <= decInvalid;
            end
        end
    end

    // Completion takes priority over an expiring timeout in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q      <= 16'h0000;
            dp_q         <= 4'h0;
            digitErr_q   <= 4'h0;
            err_q        <= 1'b0;
            valid_q      <= 1'b0;
            frameDone_q  <= 1'b0;
            timeoutCnt_q <= 24'd0;
        end else begin
            frameDone_q <= 1'b0;
            if (frameComplete) begin
                value_q      <= shadowValue_q;
                dp_q         <= shadowDp_q;
                digitErr_q   <= shadowErr_q;
                err_q        <= |shadowErr_q;
                valid_q      <= 1'b1;
                frameDone_q  <= 1'b1;
                timeoutCnt_q <= 24'd0;
            end else if (valid_q) begin
                if (timeoutCnt_q + 24'd1 == TIMEOUT_CNT) begin
                    valid_q      <= 1'b0;
                    timeoutCnt_q <= 24'd0;
                end else begin
                    timeoutCnt_q <= timeoutCnt_q + 24'd1;
                end
            end
        end
    end

    assign bus.value      = value_q;
    assign bus.dp         = dp_q;
    assign bus.digit_err  = digitErr_q;
    assign bus.err        = err_q;
    assign bus.valid      = valid_q;
    assign bus.frame_done = frameDone_q;

endmodule
